// File: rtl/imu_pkg.sv
// Shared types and constants for the gyro SPI poll sequencer.
package imu_pkg;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_INIT0,
    ST_GAP,
    ST_INIT1,
    ST_IDLE,
    ST_READ,
    ST_PUBLISH
  } state_t;

  typedef enum logic [1:0] {
    SQ_IDLE,
    SQ_PRE,
    SQ_WAIT
  } sq_state_t;

  localparam logic [7:0] SPI_RD_BIT = 8'h80;
  localparam logic [2:0] WR_BYTES   = 3'd2;
  localparam logic [2:0] RD_BYTES   = 3'd7;

  // MSB positions of each axis inside the 48-bit big-endian RX word
  localparam int RX_X_MSB = 47;
  localparam int RX_Y_MSB = 31;
  localparam int RX_Z_MSB = 15;

  localparam logic [7:0] MPU_PWR_REG  = 8'h6B;
  localparam logic [7:0] MPU_PWR_VAL  = 8'h00;
  localparam logic [7:0] MPU_CFG_REG  = 8'h1B;
  localparam logic [7:0] MPU_CFG_VAL  = 8'h18;
  localparam logic [7:0] MPU_GYRO_REG = 8'h43;

  function automatic logic [7:0] tx_byte(input logic [2:0] idx,
                                         input logic [7:0] b0,
                                         input logic [7:0] b1);
    case (idx)
      3'd0:    tx_byte = b0;
      3'd1:    tx_byte = b1;
      default: tx_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_xact_seq.sv
// One CS-framed SPI transaction: CS low, then START/DONE per byte, RX shifted in.
module spi_xact_seq
  import imu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [2:0]  nbytes,
  input  logic [7:0]  byte0,
  input  logic [7:0]  byte1,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic        cs_n,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  output logic        last,
  output logic [47:0] rx_word
);

  sq_state_t   ph;
  logic [2:0]  idx;
  logic [39:0] rx_sh;
  logic        accept;

  // A DONE only counts while a byte is outstanding and START is not high this cycle
  assign accept  = (ph == SQ_WAIT) && !spi_start && spi_done;
  assign last    = accept && (idx == (nbytes - 3'd1));
  assign rx_word = {rx_sh, spi_rx};

  // Byte handshake sequencer with registered CS/START/TX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph        <= SQ_IDLE;
      idx       <= 3'd0;
      rx_sh     <= 40'd0;
      cs_n      <= 1'b1;
      spi_start <= 1'b0;
      spi_tx    <= 8'h00;
    end else begin
      case (ph)
        SQ_IDLE: begin
          spi_start <= 1'b0;
          if (go) begin
            cs_n <= 1'b0;
            idx  <= 3'd0;
            ph   <= SQ_PRE;
          end
        end
        SQ_PRE: begin
          spi_start <= 1'b1;
          spi_tx    <= tx_byte(3'd0, byte0, byte1);
          ph        <= SQ_WAIT;
        end
        SQ_WAIT: begin
          if (accept) begin
            rx_sh <= {rx_sh[31:0], spi_rx};
            if (last) begin
              cs_n      <= 1'b1;
              spi_start <= 1'b0;
              ph        <= SQ_IDLE;
            end else begin
              spi_start <= 1'b1;
              spi_tx    <= tx_byte(idx + 3'd1, byte0, byte1);
              idx       <= idx + 3'd1;
            end
          end else begin
            spi_start <= 1'b0;
          end
        end
        default: begin
          ph        <= SQ_IDLE;
          cs_n      <= 1'b1;
          spi_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/imu_poll_sched.sv
// Gyro SPI poll scheduler: power-up hold, two config writes, then periodic 6-byte rate reads.
module imu_poll_sched
  import imu_pkg::*;
#(
  parameter int         STARTUP_CYC = 1600000,
  parameter int         TICK_CYC    = 16000,
  parameter int         CS_GAP      = 16,
  parameter logic [7:0] PWR_REG     = MPU_PWR_REG,
  parameter logic [7:0] PWR_VAL     = MPU_PWR_VAL,
  parameter logic [7:0] CFG_REG     = MPU_CFG_REG,
  parameter logic [7:0] CFG_VAL     = MPU_CFG_VAL,
  parameter logic [7:0] GYRO_REG    = MPU_GYRO_REG
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        SPI_START,
  output logic [7:0]  SPI_TX,
  input  logic [7:0]  SPI_RX,
  input  logic        SPI_DONE,
  output logic        IMU_CS_N,
  output logic [15:0] GYRO_X,
  output logic [15:0] GYRO_Y,
  output logic [15:0] GYRO_Z,
  output logic        GYRO_VALID,
  output logic        INIT_DONE,
  output logic [7:0]  OVERRUN_CNT
);

  localparam int SU_W   = $clog2(STARTUP_CYC + 1);
  localparam int GAP_W  = $clog2(CS_GAP + 1);
  localparam int TICK_W = $clog2(TICK_CYC);
  localparam logic [SU_W-1:0]   SU_LAST   = SU_W'(STARTUP_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_GAP - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);

  state_t              state, state_nxt;
  logic [SU_W-1:0]     su_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  logic                cfg_sent, pend, tick, pend_clr;
  logic                go, last;
  logic [2:0]          nbytes;
  logic [7:0]          byte0, byte1;
  logic [47:0]         rx_word;

  assign tick     = INIT_DONE && (tick_cnt == TICK_LAST);
  assign pend_clr = (state == ST_IDLE) && pend;

  spi_xact_seq u_seq (
    .clk       (CLK),
    .rst       (RST),
    .go        (go),
    .nbytes    (nbytes),
    .byte0     (byte0),
    .byte1     (byte1),
    .spi_done  (SPI_DONE),
    .spi_rx    (SPI_RX),
    .cs_n      (IMU_CS_N),
    .spi_start (SPI_START),
    .spi_tx    (SPI_TX),
    .last      (last),
    .rx_word   (rx_word)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_STARTUP;
    else     state <= state_nxt;
  end

  // Next state, transaction launch and per-state byte selection
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    nbytes    = WR_BYTES;
    byte0     = 8'h00;
    byte1     = 8'h00;
    case (state)
      ST_STARTUP: begin
        if (su_cnt == SU_LAST) begin
          state_nxt = ST_INIT0;
          go        = 1'b1;
        end else begin
          state_nxt = ST_STARTUP;
        end
      end
      ST_INIT0: begin
        byte0 = PWR_REG & 8'h7F;
        byte1 = PWR_VAL;
        if (last) state_nxt = ST_GAP;
        else      state_nxt = ST_INIT0;
      end
      ST_GAP: begin
        if (gap_cnt != GAP_LAST) begin
          state_nxt = ST_GAP;
        end else if (cfg_sent) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_INIT1;
          go        = 1'b1;
        end
      end
      ST_INIT1: begin
        byte0 = CFG_REG & 8'h7F;
        byte1 = CFG_VAL;
        if (last) state_nxt = ST_GAP;
        else      state_nxt = ST_INIT1;
      end
      ST_IDLE: begin
        if (pend) begin
          state_nxt = ST_READ;
          go        = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        nbytes = RD_BYTES;
        byte0  = SPI_RD_BIT | (GYRO_REG & 8'h7F);
        if (last) state_nxt = ST_PUBLISH;
        else      state_nxt = ST_READ;
      end
      ST_PUBLISH: state_nxt = ST_GAP;
      default:    state_nxt = ST_STARTUP;
    endcase
  end

  // Startup hold, CS gap and init-progress bookkeeping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      su_cnt    <= '0;
      gap_cnt   <= '0;
      cfg_sent  <= 1'b0;
      INIT_DONE <= 1'b0;
    end else begin
      if (state == ST_STARTUP) su_cnt <= su_cnt + 1'b1;
      if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                 gap_cnt <= '0;
      if (state == ST_INIT1 && last) cfg_sent <= 1'b1;
      if (state == ST_GAP && state_nxt == ST_IDLE) INIT_DONE <= 1'b1;
    end
  end

  // Free-running sample timer, pending-tick flag and overrun counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt    <= '0;
      pend        <= 1'b0;
      OVERRUN_CNT <= 8'd0;
    end else begin
      if (!INIT_DONE || tick_cnt == TICK_LAST) tick_cnt <= '0;
      else                                     tick_cnt <= tick_cnt + 1'b1;
      if (pend_clr)  pend <= tick;
      else if (tick) pend <= 1'b1;
      if (tick && pend && !pend_clr && OVERRUN_CNT != 8'hFF)
        OVERRUN_CNT <= OVERRUN_CNT + 8'd1;
    end
  end

  // Atomic rate publish on the cycle after the last read DONE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      GYRO_X     <= 16'h0000;
      GYRO_Y     <= 16'h0000;
      GYRO_Z     <= 16'h0000;
      GYRO_VALID <= 1'b0;
    end else begin
      GYRO_VALID <= (state == ST_READ) && last;
      if (state == ST_READ && last) begin
        GYRO_X <= rx_word[RX_X_MSB -: 16];
        GYRO_Y <= rx_word[RX_Y_MSB -: 16];
        GYRO_Z <= rx_word[RX_Z_MSB -: 16];
      end
    end
  end

endmodule
